load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and Data_Memory; feeds Data_Memory and consumes its Read_Data.
- Converts RISC-V RV64 load/store requests (byte, half, word, double; signed and unsigned) into doubleword-aligned 64-bit Data_Memory accesses.
- Sign/zero-extends load results.
- Performs read-modify-write for sub-doubleword stores.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- XLEN, 64, data and address width; only 64 is supported.

Ports:
- clock  in  1  system clock; rising edge active.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 width/sign code.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid: misaligned or illegal funct3.
- Mem_Addr  out  XLEN  Data_Memory address, bits [2:0] always 0.
- Write_Data  out  XLEN  Data_Memory write data.
- memWrite  out  1  Data_Memory write enable.
- memRead  out  1  Data_Memory read enable.
- Read_Data  in  XLEN  Data_Memory read data; combinational from Mem_Addr while memRead = 1.

Behaviour:
- Clocking and reset:
  - One clock, clock. reset is synchronous and active-high.
  - On reset, state = IDLE and all outputs = 0, including req_ready while reset is high.
  - Captured request registers clear.
- Sizes:
  - funct3 000 = B, 001 = H, 010 = W, 011 = D: signed for loads, plain for stores.
  - funct3 100 = BU, 101 = HU, 110 = WU: loads only.
  - Illegal: funct3 111, or a store with funct3 >= 100.
- Alignment:
  - Misaligned when the address is not a multiple of the access size: H needs addr[0] = 0, W needs addr[1:0] = 0, D needs addr[2:0] = 0.
  - Naturally aligned accesses never cross a doubleword.
- Request capture: a request is accepted when req_valid && req_ready. At that edge addr, wdata, funct3 and is_store are registered.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: req_ready = 1. On accept:
    - error → RESP
    - load → READ
    - store D → WRITE
    - store B/H/W → READ
  - READ: memRead = 1, Mem_Addr = {addr[63:3], 3'b000}. At the clock edge Read_Data is registered.
    - Load → RESP, with resp_rdata computed from the byte lane at offset addr[2:0]:
      - signed sizes: sign-extended
      - unsigned sizes: zero-extended
    - Store → WRITE.
  - WRITE: memWrite = 1, Mem_Addr aligned.
    - D: Write_Data = wdata.
    - Sub-doubleword: Write_Data = registered doubleword with lanes [offset*8 +: size*8] replaced by wdata[size*8-1:0].
    - → RESP.
  - RESP: resp_valid = 1 for exactly one cycle; resp_error as decided at accept; → IDLE.
- Outputs outside their active state:
  - memRead and memWrite are 0 outside READ and WRITE respectively, and are never both 1.
  - Mem_Addr and Write_Data are 0 in IDLE and RESP.
  - resp_rdata holds its value only during RESP; 0 otherwise.
- Latency from the accept edge to resp_valid:
  - error: 1 cycle
  - load: 2 cycles
  - SD: 2 cycles
  - SB/SH/SW: 3 cycles
- Throughput: req_ready is low from accept until return to IDLE, so the next request can be accepted in the cycle after RESP. There is no response backpressure; the pipeline stalls on req_ready.
- Error handling: memRead and memWrite stay 0 for the whole transaction.
- Reset mid-operation: the FSM returns to IDLE at the next edge. memWrite/memRead drop that cycle, no partial write is issued, and no resp_valid is produced for the abandoned request.
- req_valid deasserted in IDLE: no action.

Test Plan:
- LD at 0x10, memory 0x8877665544332211 → memRead one cycle, Mem_Addr = 0x10, resp_valid 2 cycles after accept, resp_rdata = 0x8877665544332211, resp_error = 0.
- LB at 0x17, then LBU at 0x17, same doubleword → resp_rdata = 0xFFFFFFFFFFFFFF88, then 0x0000000000000088; LW at 0x14 → 0xFFFFFFFF88776655; LHU at 0x12 → 0x0000000000004433.
- SB 0xAB at 0x13 over the doubleword above → READ then WRITE, Mem_Addr = 0x10, Write_Data = 0x88776655AB332211, resp_valid 3 cycles after accept; a following LD at 0x10 returns that value.
- SD 0x1122334455667788 at 0x18 → no memRead, one memWrite, Write_Data = 0x1122334455667788, resp_valid 2 cycles after accept.
- LW at 0x12, SH at 0x11, funct3 = 111, and SB-type store with funct3 = 100 → each gives resp_valid 1 cycle after accept with resp_error = 1, resp_rdata = 0, memRead and memWrite never asserted.
- Reset for one cycle while in WRITE of an SW → memWrite low from the next cycle, memory unchanged, no resp_valid, req_ready = 1 one cycle after reset drops; back-to-back requests: req_ready low while busy, second request accepted the cycle after the first's resp_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// RV64 load/store unit: turns byte/half/word/double requests into aligned
// doubleword Data_Memory accesses, with read-modify-write for narrow stores.
module load_store_unit #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic [XLEN-1:0] Mem_Addr,
    output logic [XLEN-1:0] Write_Data,
    output logic            memWrite,
    output logic            memRead,
    input  logic [XLEN-1:0] Read_Data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            store_q, store_d;
    logic            err_q, err_d;

    logic            req_misaligned;
    logic            req_illegal;
    logic            req_err;
    logic [XLEN-1:0] aligned_addr;
    logic [5:0]      lane_shift;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_data;
    logic [7:0]      size_mask;
    logic [7:0]      lane_en;
    logic [XLEN-1:0] st_shifted;
    logic [XLEN-1:0] st_merged;

    // Request classification, evaluated on the live request in IDLE.
    always_comb begin
        req_misaligned = 1'b0;
        unique case (req_funct3[1:0])
            2'b00: req_misaligned = 1'b0;
            2'b01: req_misaligned = req_addr[0];
            2'b10: req_misaligned = |req_addr[1:0];
            2'b11: req_misaligned = |req_addr[2:0];
        endcase
        req_illegal = (req_funct3 == 3'b111)
                    || (req_is_store && req_funct3[2]);
        req_err     = req_misaligned || req_illegal;
    end

    assign aligned_addr = {addr_q[XLEN-1:3], 3'b000};
    assign lane_shift   = {addr_q[2:0], 3'b000};

    // Load path: shift the addressed lane down, then extend by size/sign.
    always_comb begin
        ld_shifted = rdata_q >> lane_shift;
        ld_data    = '0;
        unique case (funct3_q[1:0])
            2'b00: ld_data = {{56{~funct3_q[2] & ld_shifted[7]}},
                              ld_shifted[7:0]};
            2'b01: ld_data = {{48{~funct3_q[2] & ld_shifted[15]}},
                              ld_shifted[15:0]};
            2'b10: ld_data = {{32{~funct3_q[2] & ld_shifted[31]}},
                              ld_shifted[31:0]};
            2'b11: ld_data = ld_shifted;
        endcase
    end

    // Store path: only the lanes covered by the access take new data.
    always_comb begin
        size_mask = 8'h00;
        unique case (funct3_q[1:0])
            2'b00: size_mask = 8'h01;
            2'b01: size_mask = 8'h03;
            2'b10: size_mask = 8'h0F;
            2'b11: size_mask = 8'hFF;
        endcase
        lane_en    = size_mask << addr_q[2:0];
        st_shifted = wdata_q << lane_shift;
        st_merged  = rdata_q;
        for (int i = 0; i < 8; i++) begin
            if (lane_en[i]) begin
                st_merged[i*8 +: 8] = st_shifted[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        funct3_d   = funct3_q;
        store_d    = store_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_error = 1'b0;
        Mem_Addr   = '0;
        Write_Data = '0;
        memWrite   = 1'b0;
        memRead    = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    store_d  = req_is_store;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_is_store
                                 && req_funct3[1:0] == 2'b11) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                memRead  = 1'b1;
                Mem_Addr = aligned_addr;
                rdata_d  = Read_Data;
                state_d  = store_q ? WRITE : RESP;
            end
            WRITE: begin
                memWrite   = 1'b1;
                Mem_Addr   = aligned_addr;
                Write_Data = st_merged;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_rdata = (store_q || err_q) ? '0 : ld_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are forced quiet while reset is held so nothing leaks
        // to memory from an abandoned transaction.
        if (reset) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_rdata = '0;
            resp_error = 1'b0;
            Mem_Addr   = '0;
            Write_Data = '0;
            memWrite   = 1'b0;
            memRead    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases, mid-op reset and
// randomized traffic against a byte-level reference memory.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        memWrite;
    logic        memRead;
    logic [63:0] Read_Data;

    load_store_unit #(.XLEN(64)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_is_store(req_is_store),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_error(resp_error),
        .Mem_Addr(Mem_Addr),
        .Write_Data(Write_Data),
        .memWrite(memWrite),
        .memRead(memRead),
        .Read_Data(Read_Data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] init_val(input int i);
        if (i == 2) return 64'h8877665544332211;
        return 64'h9E3779B97F4A7C15 * 64'(i + 3);
    endfunction

    // Data_Memory stand-in: 32 doublewords, combinational read.
    logic [63:0] mem [32];
    logic        mem_load;
    always @(posedge clock) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (memWrite) begin
            mem[Mem_Addr[7:3]] <= Write_Data;
        end
    end
    assign Read_Data = memRead ? mem[Mem_Addr[7:3]] : 64'h0;

    logic [63:0] refmem [32];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [63:0] maddr;
    } exp_t;

    typedef struct {
        logic [63:0] maddr;
        logic [63:0] data;
    } wr_t;

    exp_t q[$];
    wr_t  wq[$];

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;
    bit b2b    = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: byte-granular view of the access rules.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input bit lit_en, input logic [63:0] lit);
        int          n;
        int          nbytes;
        int          off;
        int          idx;
        bit          err;
        logic [63:0] v;
        logic [63:0] mask;
        logic [63:0] nd;
        exp_t        e;
        wr_t         w;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        nbytes = 1 << f3[1:0];
        off    = int'(a % 8);
        idx    = int'(a[7:3]);
        err    = (f3 == 3'b111) || (st && f3[2]) || ((a % nbytes) != 0);
        e.maddr = a & ~64'h7;
        e.rdata = 64'h0;
        e.err   = err;
        if (err) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (!st) begin
            e.lat = 2; e.nrd = 1; e.nwr = 0;
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            v = (refmem[idx] >> (8 * off)) & mask;
            if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
            e.rdata = v;
        end else begin
            e.lat = (nbytes == 8) ? 2 : 3;
            e.nrd = (nbytes == 8) ? 0 : 1;
            e.nwr = 1;
            nd = refmem[idx];
            for (int b = 0; b < nbytes; b++)
                nd[8*(off+b) +: 8] = wd[8*b +: 8];
            refmem[idx] = nd;
            w.maddr = e.maddr;
            w.data  = nd;
            wq.push_back(w);
        end
        if (lit_en) e.rdata = lit;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0) && n < 50) begin
            @(posedge clock);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        chk("wr_drain", 64'(wq.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    // Monitor: tracks each transaction from accept to response.
    initial begin
        bit   busy;
        bit   have_resp;
        int   acc, last_resp, nrd, nwr, rdy_hi, nzr;
        exp_t e;
        wr_t  w;
        busy = 0; have_resp = 0;
        acc = 0; last_resp = 0;
        nrd = 0; nwr = 0; rdy_hi = 0; nzr = 0;
        forever begin
            @(negedge clock);
            if (mon_en && !reset) begin
                if (busy) begin
                    if (req_ready) rdy_hi++;
                    if (memRead) begin
                        nrd++;
                        if (q.size() > 0) chk("rd_addr", Mem_Addr, q[0].maddr);
                    end
                    if (memWrite) begin
                        nwr++;
                        if (wq.size() > 0) begin
                            w = wq.pop_front();
                            chk("wr_addr", Mem_Addr, w.maddr);
                            chk("wr_data", Write_Data, w.data);
                        end else chk("wr_unexpected", 64'd1, 64'd0);
                    end
                    if (!resp_valid && resp_rdata != 64'h0) nzr++;
                    if (resp_valid) begin
                        if (q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
                        else begin
                            e = q.pop_front();
                            chk("rdata", resp_rdata, e.rdata);
                            chk("error", 64'(resp_error), 64'(e.err));
                            chk("latency", 64'(cyc - acc), 64'(e.lat));
                            chk("n_read", 64'(nrd), 64'(e.nrd));
                            chk("n_write", 64'(nwr), 64'(e.nwr));
                            chk("ready_busy", 64'(rdy_hi), 64'd0);
                            chk("rdata_idle", 64'(nzr), 64'd0);
                            chk("bus_in_resp", Mem_Addr | Write_Data, 64'h0);
                        end
                        busy = 0;
                        last_resp = cyc;
                        have_resp = 1;
                    end
                end else if (resp_valid) begin
                    chk("resp_spurious", 64'd1, 64'd0);
                end
                if (!busy && req_valid && req_ready) begin
                    if (b2b && have_resp)
                        chk("b2b_gap", 64'(cyc), 64'(last_resp + 1));
                    busy = 1; acc = cyc;
                    nrd = 0; nwr = 0; rdy_hi = 0; nzr = 0;
                end
            end
        end
    end

    initial begin
        int nresp;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] wd;
        int          nb;
        for (int i = 0; i < 32; i++) refmem[i] = init_val(i);
        reset = 1'b1; mem_load = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 64'h0; req_wdata = 64'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs",
            {56'h0, req_ready, resp_valid, memRead, memWrite, resp_error,
             |Mem_Addr, |Write_Data, |resp_rdata}, 64'h0);
        reset = 1'b0; mem_load = 1'b0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        b2b = 0;
        issue(0, 3'b011, 64'h10, 64'h0, 1, 64'h8877665544332211); b2b = 1;
        issue(0, 3'b000, 64'h17, 64'h0, 1, 64'hFFFFFFFFFFFFFF88);
        issue(0, 3'b100, 64'h17, 64'h0, 1, 64'h0000000000000088);
        issue(0, 3'b010, 64'h14, 64'h0, 1, 64'hFFFFFFFF88776655);
        issue(0, 3'b101, 64'h12, 64'h0, 1, 64'h0000000000004433);
        issue(1, 3'b000, 64'h13, 64'hAB, 1, 64'h0);
        issue(0, 3'b011, 64'h10, 64'h0, 1, 64'h88776655AB332211);
        issue(1, 3'b011, 64'h18, 64'h1122334455667788, 1, 64'h0);
        issue(0, 3'b011, 64'h18, 64'h0, 1, 64'h1122334455667788);
        issue(0, 3'b010, 64'h12, 64'h0, 1, 64'h0);
        issue(1, 3'b001, 64'h11, 64'h5555, 1, 64'h0);
        issue(0, 3'b111, 64'h20, 64'h0, 1, 64'h0);
        issue(1, 3'b100, 64'h20, 64'h77, 1, 64'h0);
        req_valid = 1'b0; b2b = 0;
        drain();

        // Reset while an SW sits in WRITE: no write, no response.
        mon_en = 1'b0;
        req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 64'h44; req_wdata = 64'hDEADBEEFCAFEF00D;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_in_write", 64'(memWrite), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_outputs_mid",
            {60'h0, req_ready, memWrite, memRead, resp_valid}, 64'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready_after", 64'(req_ready), 64'd1);
        chk("rst_mem_kept", mem[8], refmem[8]);
        nresp = 0;
        repeat (4) begin
            if (resp_valid) nresp++;
            @(negedge clock);
        end
        chk("rst_no_resp", 64'(nresp), 64'd0);
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        b2b = 0;

        for (int k = 0; k < 250; k++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            nb = 1 << f3[1:0];
            a  = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 7) a = a & ~64'(nb - 1);
            wd = {$urandom, $urandom};
            issue(st, f3, a, wd, 0, 64'h0);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                b2b = 0;
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end else begin
                b2b = 1;
            end
        end
        req_valid = 1'b0; b2b = 0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
